// File: rtl/video_pattern_gen.sv
// ---------------------------------------------------------------------------
// video_pattern_gen
//
// AXI4-Stream video test-pattern source. Emits H_RES x V_RES frames of packed
// 30-bit pixels {2'b0, R[29:20], B[19:10], G[9:0]}. tuser marks the first
// pixel of a frame and tlast marks the last pixel of each line. An optional
// noise overlay from a 32-bit Galois LFSR is added per channel with
// saturation. The LFSR reseeds at every frame start, so every frame is
// reproducible.
//
// Ports:
//   aclk, aresetn     clock, asynchronous active-low reset
//   enable            run request, sampled only at frame boundaries
//   pattern_sel       0 solid, 1 colour bars, 2 horizontal ramp, 3 checker
//   solid_color       {R,B,G} colour used by the solid pattern
//   noise_mask        per-channel mask on the LFSR bits added to each pixel
//   m_axis_*          AXI4-Stream master (tdata/tvalid/tready/tlast/tuser)
//   frame_cnt         number of completed frames, wraps at 16 bits
//   busy              high whenever the generator is not idle
// ---------------------------------------------------------------------------
module video_pattern_gen #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          H_RES        = 1920,
  parameter int          V_RES        = 1080,
  parameter int          H_BLANK      = 0,
  parameter int          CHECKER_LOG2 = 6,
  parameter logic [31:0] LFSR_SEED    = 32'hACE1_2468
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  enable,
  input  logic [1:0]            pattern_sel,
  input  logic [29:0]           solid_color,
  input  logic [9:0]            noise_mask,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic [15:0]           frame_cnt,
  output logic                  busy
);

  localparam int          BAR_LEN   = H_RES / 8;
  // Galois taps for x^32 + x^22 + x^2 + x + 1 in right-shift form
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {IDLE, ACTIVE, BLANK} state_t;

  state_t      state;
  logic [15:0] x;
  logic [15:0] y;
  logic [15:0] bar_cnt;
  logic [2:0]  bar_idx;
  logic [15:0] blank_cnt;
  logic        blank_eof;
  logic [31:0] lfsr;
  logic [1:0]  pat_q;
  logic [29:0] solid_q;
  logic [9:0]  mask_q;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

  function automatic logic [9:0] sat_add(input logic [9:0] base, input logic [9:0] noise);
    logic [10:0] sum;
    sum = {1'b0, base} + {1'b0, noise};
    return sum[10] ? 10'h3FF : sum[9:0];
  endfunction

  function automatic logic [29:0] bar_color(input logic [2:0] idx);
    logic [29:0] c;
    case (idx)
      3'd0:    c = 30'h3FFF_FFFF;
      3'd1:    c = 30'h3FF0_03FF;
      3'd2:    c = 30'h000F_FFFF;
      3'd3:    c = 30'h0000_03FF;
      3'd4:    c = 30'h3FFF_FC00;
      3'd5:    c = 30'h3FF0_0000;
      3'd6:    c = 30'h000F_FC00;
      default: c = 30'h0000_0000;
    endcase
    return c;
  endfunction

  function automatic logic [29:0] make_pixel(
    input logic [1:0]  pat,
    input logic [29:0] solid,
    input logic [9:0]  mask,
    input logic [15:0] px,
    input logic [15:0] py,
    input logic [2:0]  bidx,
    input logic [31:0] noise
  );
    logic [29:0] base;
    case (pat)
      2'd0:    base = solid;
      2'd1:    base = bar_color(bidx);
      2'd2:    base = {3{px[10:1]}};
      default: base = (px[CHECKER_LOG2] ^ py[CHECKER_LOG2]) ? 30'h3FFF_FFFF : 30'h0;
    endcase
    return {sat_add(base[29:20], noise[29:20] & mask),
            sat_add(base[19:10], noise[19:10] & mask),
            sat_add(base[9:0],   noise[9:0]   & mask)};
  endfunction

  logic        handshake;
  logic        eol;
  logic        last_line;
  logic        blank_done;
  logic [15:0] adv_x;
  logic [15:0] adv_y;
  logic [15:0] adv_bar_cnt;
  logic [2:0]  adv_bar_idx;
  logic [31:0] adv_lfsr;

  // ACTIVE always drives tvalid=1, so a handshake is ACTIVE plus tready
  assign handshake  = (state == ACTIVE) && m_axis_tready;
  assign eol        = (x == 16'(H_RES - 1));
  assign last_line  = (y == 16'(V_RES - 1));
  assign blank_done = (blank_cnt == 16'(H_BLANK - 1));

  // Position and noise state that follow the current beat once it is
  // accepted; the bar counter replaces a divide of x by H_RES/8
  always_comb begin
    adv_lfsr    = lfsr_step(lfsr);
    adv_x       = x + 16'd1;
    adv_y       = y;
    adv_bar_cnt = bar_cnt + 16'd1;
    adv_bar_idx = bar_idx;
    if (eol) begin
      adv_x       = 16'd0;
      adv_y       = last_line ? 16'd0 : y + 16'd1;
      adv_bar_cnt = 16'd0;
      adv_bar_idx = 3'd0;
    end else if (bar_cnt == 16'(BAR_LEN - 1)) begin
      adv_bar_cnt = 16'd0;
      adv_bar_idx = bar_idx + 3'd1;
    end
  end

  logic        frame_end;
  logic        new_frame;
  logic        load_beat;
  logic [15:0] src_x;
  logic [15:0] src_y;
  logic [15:0] src_bar_cnt;
  logic [2:0]  src_bar_idx;
  logic [31:0] src_lfsr;
  logic [1:0]  src_pat;
  logic [29:0] src_solid;
  logic [9:0]  src_mask;
  logic [29:0] src_pixel;

  // Decide whether a beat is loaded at this edge and from which state.
  // A new frame takes the live control inputs and the seed; a continuing
  // beat uses the latched controls. Returning from BLANK uses the position
  // already advanced when the line ended.
  always_comb begin
    frame_end   = 1'b0;
    new_frame   = 1'b0;
    load_beat   = 1'b0;
    src_x       = x;
    src_y       = y;
    src_bar_cnt = bar_cnt;
    src_bar_idx = bar_idx;
    src_lfsr    = lfsr;
    src_pat     = pat_q;
    src_solid   = solid_q;
    src_mask    = mask_q;
    case (state)
      IDLE: new_frame = enable;
      ACTIVE: begin
        if (handshake) begin
          if (eol && (H_BLANK != 0)) begin
            load_beat = 1'b0;
          end else if (eol && last_line) begin
            frame_end = 1'b1;
          end else begin
            load_beat   = 1'b1;
            src_x       = adv_x;
            src_y       = adv_y;
            src_bar_cnt = adv_bar_cnt;
            src_bar_idx = adv_bar_idx;
            src_lfsr    = adv_lfsr;
          end
        end
      end
      BLANK: begin
        if (blank_done) begin
          if (blank_eof) frame_end = 1'b1;
          else           load_beat = 1'b1;
        end
      end
      default: load_beat = 1'b0;
    endcase
    if (frame_end) new_frame = enable;
    if (new_frame) begin
      load_beat   = 1'b1;
      src_x       = 16'd0;
      src_y       = 16'd0;
      src_bar_cnt = 16'd0;
      src_bar_idx = 3'd0;
      src_lfsr    = LFSR_SEED;
      src_pat     = pattern_sel;
      src_solid   = solid_color;
      src_mask    = noise_mask;
    end
  end

  assign src_pixel = make_pixel(src_pat, src_solid, src_mask, src_x, src_y,
                                src_bar_idx, src_lfsr);

  // Main FSM and registered stream outputs
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= IDLE;
      x             <= 16'd0;
      y             <= 16'd0;
      bar_cnt       <= 16'd0;
      bar_idx       <= 3'd0;
      blank_cnt     <= 16'd0;
      blank_eof     <= 1'b0;
      lfsr          <= LFSR_SEED;
      pat_q         <= 2'd0;
      solid_q       <= 30'd0;
      mask_q        <= 10'd0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      frame_cnt     <= 16'd0;
      busy          <= 1'b0;
    end else begin
      if (handshake && eol && last_line) frame_cnt <= frame_cnt + 16'd1;

      if (load_beat) begin
        state         <= ACTIVE;
        busy          <= 1'b1;
        x             <= src_x;
        y             <= src_y;
        bar_cnt       <= src_bar_cnt;
        bar_idx       <= src_bar_idx;
        lfsr          <= src_lfsr;
        pat_q         <= src_pat;
        solid_q       <= src_solid;
        mask_q        <= src_mask;
        m_axis_tdata  <= DATA_WIDTH'(src_pixel);
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= (src_x == 16'(H_RES - 1));
        m_axis_tuser  <= (src_x == 16'd0) && (src_y == 16'd0);
      end else if (handshake) begin
        // Line ended without an immediate next beat
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
        m_axis_tuser  <= 1'b0;
        if (frame_end) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else begin
          state     <= BLANK;
          blank_cnt <= 16'd0;
          blank_eof <= last_line;
          x         <= adv_x;
          y         <= adv_y;
          bar_cnt   <= adv_bar_cnt;
          bar_idx   <= adv_bar_idx;
          lfsr      <= adv_lfsr;
        end
      end else if (state == BLANK) begin
        if (blank_done) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else begin
          blank_cnt <= blank_cnt + 16'd1;
        end
      end
    end
  end

endmodule
